orientation_window_ctrl: RTL

- Front-end sequencer for the column-streamed 7x7 orientation datapath (the moment unit that takes one 56-bit column per cycle and produces 13-bit signed mx/my).
- Accepts a raster pixel stream, keeps 6 line buffers, and presents one 7-pixel column per accepted pixel.
- Tracks window position and column contiguity, because the datapath has no enable and needs 7 bubble-free consecutive columns per window.
- Emits a tagged, registered moment result with the window-centre coordinate, and pulses frame-done after the pipeline drains.

---
 rtl/orientation_window_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/orientation_window_ctrl.sv
// rtl/orientation_window_ctrl.sv - raster-to-column sequencer and window tagger for the 7x7 orientation datapath
module orientation_window_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [7:0]         i_pix,
  output logic               o_ready,
  output logic [55:0]        o_col,
  input  logic signed [12:0] i_mx,
  input  logic signed [12:0] i_my,
  output logic               o_valid,
  output logic [XW-1:0]      o_cx,
  output logic [YW-1:0]      o_cy,
  output logic signed [12:0] o_mx,
  output logic signed [12:0] o_my,
  output logic               o_frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cur_x;
  logic [YW-1:0]   y_q, y_d, cur_y;
  logic [2:0]      run_q, run_d;
  logic [1:0]      drain_q, drain_d;
  logic            prev_xfer_q;
  logic            pix_ok, tag_new;
  logic [55:0]     col_d;
  logic            tag0_v_q, tag1_v_q;
  logic [XW-1:0]   tag0_x_q, tag1_x_q;
  logic [YW-1:0]   tag0_y_q, tag1_y_q;

  // lb_q[0] is the oldest row (y-6), lb_q[5] the previous row (y-1)
  logic [7:0]      lb_q [6][WIDTH];

  assign o_ready      = (state_q != S_DRAIN);
  assign o_frame_done = (state_q == S_DRAIN) && (drain_q == 2'd3);

  always_comb begin
    pix_ok  = i_valid && o_ready && (i_sof || state_q == S_ACTIVE);
    cur_x   = i_sof ? '0 : x_q;
    cur_y   = i_sof ? '0 : y_q;
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    drain_d = drain_q;
    if (pix_ok) begin
      state_d = S_ACTIVE;
      if (cur_x == '0 || !prev_xfer_q) run_d = 3'd0;
      else if (run_q != 3'd6)          run_d = run_q + 3'd1;
      if (cur_x == XW'(WIDTH - 1)) begin
        x_d = '0;
        if (cur_y == YW'(HEIGHT - 1)) begin
          y_d     = '0;
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end else if (state_q == S_DRAIN) begin
      drain_d = drain_q + 2'd1;
      if (drain_q == 2'd3) state_d = S_IDLE;
    end
    tag_new = pix_ok && (cur_x >= XW'(6)) && (cur_y >= YW'(6)) && (run_d == 3'd6);
    for (int i = 0; i < 6; i++) col_d[8*i +: 8] = lb_q[i][cur_x];
    col_d[55:48] = i_pix;
  end

  always_ff @(posedge i_clk) begin
    if (pix_ok) begin
      for (int i = 0; i < 5; i++) lb_q[i][cur_x] <= lb_q[i+1][cur_x];
      lb_q[5][cur_x] <= i_pix;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      run_q       <= '0;
      drain_q     <= '0;
      prev_xfer_q <= 1'b0;
      o_col       <= '0;
      tag0_v_q    <= 1'b0;
      tag0_x_q    <= '0;
      tag0_y_q    <= '0;
      tag1_v_q    <= 1'b0;
      tag1_x_q    <= '0;
      tag1_y_q    <= '0;
      o_valid     <= 1'b0;
      o_cx        <= '0;
      o_cy        <= '0;
      o_mx        <= '0;
      o_my        <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      run_q       <= run_d;
      drain_q     <= drain_d;
      prev_xfer_q <= pix_ok;
      if (pix_ok) o_col <= col_d;
      // stage 0 aligns with o_col, stage 1 with the datapath result
      tag0_v_q    <= tag_new;
      tag0_x_q    <= cur_x - XW'(3);
      tag0_y_q    <= cur_y - YW'(3);
      tag1_v_q    <= tag0_v_q;
      tag1_x_q    <= tag0_x_q;
      tag1_y_q    <= tag0_y_q;
      o_valid     <= tag1_v_q;
      if (tag1_v_q) begin
        o_cx <= tag1_x_q;
        o_cy <= tag1_y_q;
        o_mx <= i_mx;
        o_my <= i_my;
      end
    end
  end

endmodule
